text_scanout: RTL and testbench
===============================

Name: text_scanout

Overview:
- Read side of the text display memory: fetches character cells during active video and renders them to a stream of 4-bit pixel colour indices for the video output stage.
- Each cell is 16 bits: [15:12] back colour, [11:8] fore colour, [7:0] character code.
- For each cell it reads the display RAM, then reads one byte of the font ROM, then shifts out 8 pixels.
- Display RAM and font ROM are both synchronous-read memories with 1-cycle latency.

Parameters:
- TEXT_COLS, 80, character cells per text row.
- TEXT_ROWS, 30, text rows per frame; the cell address wraps at TEXT_COLS*TEXT_ROWS.
- FONT_H, 16, scanlines per glyph. Must be a power of two. FONT_W is fixed at 8.
- ADDR_W, 12, display address width. Must match disp_addr_t.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active low
- frame_start_i  in  1  1-cycle pulse; next line is text row 0, scanline 0
- line_start_i  in  1  1-cycle pulse, 3 cycles before first visible pixel of a text-bearing line
- rd_en_o  out  1  display RAM read strobe
- rd_addr_o  out  ADDR_W  display RAM read address
- rd_data_i  in  16  display RAM data, valid the cycle after rd_en_o
- font_addr_o  out  8+log2(FONT_H)  {char[7:0], scanline}
- font_data_i  in  8  glyph byte, valid the cycle after font_addr_o; bit 7 is the leftmost pixel
- pix_valid_o  out  1  pixel output valid
- pix_color_o  out  4  pixel colour index

Behaviour:
- Reset (reset_n low at a clk edge):
  - rd_en_o=0, rd_addr_o=0, font_addr_o=0, pix_valid_o=0, pix_color_o=0.
  - line_base=0, scanline=0, state IDLE.
  - Reset mid-line aborts the line immediately.
- States:
  - IDLE: waiting for line_start_i.
  - ACTIVE: fetch/shift, for TEXT_COLS*8 pixels.
  - DRAIN: last cell shifting, no more fetches.
  - Return to IDLE after the final pixel.
- Timing, with line_start_i sampled at cycle T:
  - Cell fetch n (n = 0..TEXT_COLS-1) at cycle T+8n: rd_en_o=1, rd_addr_o = line_base+n.
  - Cycle T+8n+1: capture rd_data_i colours; font_addr_o = {rd_data_i[7:0], scanline}.
  - Cycle T+8n+2: load font_data_i and the captured colours into the shift/colour registers.
  - Pixel x (x = 0..TEXT_COLS*8-1) is output at cycle T+3+x: pix_valid_o=1, pix_color_o = glyph bit ? fore : back.
  - Pixels are MSB first; the output is registered.
  - rd_en_o is high only on fetch cycles. font_addr_o holds its value between fetches.
- Outside active pixels: pix_valid_o=0, pix_color_o=0.
- End of line, same cycle as the last pixel:
  - If scanline==FONT_H-1: scanline wraps to 0, and line_base += TEXT_COLS.
  - If the new line_base would be ≥ TEXT_COLS*TEXT_ROWS, it becomes 0.
  - Otherwise scanline += 1.
- frame_start_i: in any state, forces line_base=0, scanline=0. It does not start a line.
- frame_start_i and line_start_i in the same cycle: the frame reset applies first. The line starts at base 0, scanline 0.
- line_start_i during ACTIVE/DRAIN:
  - Aborts the current line without advancing scanline/line_base.
  - Restarts at cycle T with the same row/scanline.
  - Pixels already in the pipeline are discarded: pix_valid_o=0 until T+3.
- Address arithmetic: ADDR_W bits, unsigned. scanline is log2(FONT_H) bits.

Test Plan:
1. Reset: hold reset_n=0 for 4 cycles with line_start_i pulsing -> rd_en_o=0, pix_valid_o=0, pix_color_o=0 throughout. Lines started before release produce nothing.
2. Single cell:
   - Stimulus: frame_start_i, then line_start_i at T. RAM[0]=16'h1241; font byte for {8'h41,4'h0} = 8'b1000_0001.
   - rd_addr_o=0 at T; font_addr_o=12'h410 at T+1.
   - pix_color_o at T+3..T+10 = 2,1,1,1,1,1,1,2, with pix_valid_o=1.
   - rd_addr_o=1 at T+8.
3. Full line: one line_start_i ->
   - exactly 80 rd_en_o pulses, addresses 0..79 at T+8n;
   - 640 valid pixels, T+3..T+642;
   - pix_valid_o=0 at T+643.
4. Row advance:
   - 16 complete lines after frame_start_i -> line 17 fetches addresses 80..159 with scanline 0.
   - Line 2 uses font_addr_o low nibble = 1.
5. Wrap:
   - 480 lines -> next line (no frame_start_i) fetches from address 0.
   - frame_start_i and line_start_i in the same cycle mid-frame -> rd_addr_o=0 and scanline 0.
6. Abort: line_start_i at pixel 100 of a line ->
   - pix_valid_o=0 for 3 cycles;
   - restart fetch at address line_base;
   - scanline is not incremented.

Source files
------------

// File: rtl/text_scanout.sv
// Text-mode scan-out: fetches character cells from the display RAM, looks up
// one glyph row per cell in the font ROM and serialises it as 4-bit colour
// indices, eight pixels per cell, MSB (leftmost) first.
module text_scanout #(
    parameter int TEXT_COLS = 80,
    parameter int TEXT_ROWS = 30,
    parameter int FONT_H    = 16,
    parameter int ADDR_W    = 12
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          frame_start_i,
    input  logic                          line_start_i,
    output logic                          rd_en_o,
    output logic [ADDR_W-1:0]             rd_addr_o,
    input  logic [15:0]                   rd_data_i,
    output logic [8+$clog2(FONT_H)-1:0]   font_addr_o,
    input  logic [7:0]                    font_data_i,
    output logic                          pix_valid_o,
    output logic [3:0]                    pix_color_o
);

    localparam int SCAN_W   = $clog2(FONT_H);
    localparam int LINE_PIX = TEXT_COLS * 8;
    localparam int CYC_W    = $clog2(LINE_PIX + 3);
    localparam int CELLS    = TEXT_COLS * TEXT_ROWS;

    typedef logic [ADDR_W-1:0] disp_addr_t;
    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t             state_reg, state_next;
    logic [CYC_W-1:0]   cyc_reg, cyc_next;      // cycles since line start
    disp_addr_t         base_reg, base_next;    // first cell of current text row
    logic [SCAN_W-1:0]  scan_reg, scan_next;    // glyph scanline
    logic [ADDR_W:0]    base_sum;
    logic               line_end;

    disp_addr_t         rd_addr_reg;
    logic [8+SCAN_W-1:0] font_addr_reg;
    logic               cap_reg;                // RAM data valid this cycle
    logic               ld_reg;                 // font data valid this cycle
    logic [3:0]         fore_reg, back_reg;     // colours of the cell being looked up
    logic [3:0]         cell_fore_reg, cell_back_reg; // colours of the cell being shifted
    logic [7:0]         shift_reg;
    logic [2:0]         left_reg;               // pixels still to shift from shift_reg
    logic               pix_valid_reg;
    logic [3:0]         pix_color_reg;

    // Last pixel of the line is on screen during the final DRAIN cycle.
    assign line_end = (state_reg == DRAIN) && (cyc_reg == CYC_W'(LINE_PIX + 2));
    assign base_sum = {1'b0, base_reg} + (ADDR_W+1)'(TEXT_COLS);

    // Next-state logic; a line start overrides everything and never advances the row.
    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        base_next  = base_reg;
        scan_next  = scan_reg;
        case (state_reg)
            IDLE: begin
            end
            ACTIVE: begin
                cyc_next = cyc_reg + CYC_W'(1);
                if (cyc_reg == CYC_W'(LINE_PIX - 1))
                    state_next = DRAIN;
            end
            DRAIN: begin
                cyc_next = cyc_reg + CYC_W'(1);
                if (line_end) begin
                    state_next = IDLE;
                    cyc_next   = '0;
                    if (scan_reg == SCAN_W'(FONT_H - 1)) begin
                        scan_next = '0;
                        base_next = (base_sum >= (ADDR_W+1)'(CELLS)) ? '0 : base_sum[ADDR_W-1:0];
                    end else begin
                        scan_next = scan_reg + SCAN_W'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (frame_start_i) begin
            base_next = '0;
            scan_next = '0;
        end
        if (line_start_i) begin
            state_next = ACTIVE;
            cyc_next   = '0;
            if (!frame_start_i) begin
                base_next = base_reg;
                scan_next = scan_reg;
            end
        end
    end

    // FSM and line-position registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cyc_reg   <= '0;
            base_reg  <= '0;
            scan_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cyc_reg   <= cyc_next;
            base_reg  <= base_next;
            scan_reg  <= scan_next;
        end
    end

    // Cell fetch happens on the first cycle of every 8-cycle slot while ACTIVE.
    assign rd_en_o     = (state_reg == ACTIVE) && (cyc_reg[2:0] == 3'd0);
    assign rd_addr_o   = rd_addr_reg;
    // Font address follows RAM data in the cycle it arrives, then holds.
    assign font_addr_o = cap_reg ? {rd_data_i[7:0], scan_reg} : font_addr_reg;

    // Display address: loaded at line start, stepped after each fetch slot.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_addr_reg <= '0;
        end else if (line_start_i) begin
            rd_addr_reg <= base_next;
        end else if ((state_reg == ACTIVE) && (cyc_reg[2:0] == 3'd7) &&
                     (cyc_reg != CYC_W'(LINE_PIX - 1))) begin
            rd_addr_reg <= rd_addr_reg + ADDR_W'(1);
        end
    end

    // Fetch pipeline: RAM data capture, then font lookup; a restart flushes it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cap_reg       <= 1'b0;
            ld_reg        <= 1'b0;
            fore_reg      <= '0;
            back_reg      <= '0;
            font_addr_reg <= '0;
        end else begin
            cap_reg <= rd_en_o && !line_start_i;
            ld_reg  <= cap_reg && !line_start_i;
            if (cap_reg) begin
                fore_reg      <= rd_data_i[11:8];
                back_reg      <= rd_data_i[15:12];
                font_addr_reg <= font_addr_o;
            end
        end
    end

    // Pixel shifter with registered colour output.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            shift_reg     <= '0;
            left_reg      <= '0;
            cell_fore_reg <= '0;
            cell_back_reg <= '0;
            pix_valid_reg <= 1'b0;
            pix_color_reg <= '0;
        end else if (line_start_i) begin
            left_reg      <= '0;
            pix_valid_reg <= 1'b0;
            pix_color_reg <= '0;
        end else if (ld_reg) begin
            shift_reg     <= {font_data_i[6:0], 1'b0};
            left_reg      <= 3'd7;
            cell_fore_reg <= fore_reg;
            cell_back_reg <= back_reg;
            pix_valid_reg <= 1'b1;
            pix_color_reg <= font_data_i[7] ? fore_reg : back_reg;
        end else if (left_reg != 3'd0) begin
            shift_reg     <= {shift_reg[6:0], 1'b0};
            left_reg      <= left_reg - 3'd1;
            pix_valid_reg <= 1'b1;
            pix_color_reg <= shift_reg[7] ? cell_fore_reg : cell_back_reg;
        end else begin
            pix_valid_reg <= 1'b0;
            pix_color_reg <= '0;
        end
    end

    assign pix_valid_o = pix_valid_reg;
    assign pix_color_o = pix_color_reg;

endmodule

// File: tb/tb_text_scanout.sv
// Bench for text_scanout: random display/font contents, per-cycle comparison
// of fetch strobes, addresses and pixels against an arithmetic line model.
module tb_text_scanout;

    // Two text rows keep a full frame wrap short; columns and font height are the defaults.
    localparam int COLS     = 80;
    localparam int ROWS     = 2;
    localparam int FH       = 16;
    localparam int AW       = 12;
    localparam int LINE_PIX = COLS * 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           frame_start_i;
    logic           line_start_i;
    logic           rd_en_o;
    logic [AW-1:0]  rd_addr_o;
    logic [15:0]    rd_data_i;
    logic [11:0]    font_addr_o;
    logic [7:0]     font_data_i;
    logic           pix_valid_o;
    logic [3:0]     pix_color_o;

    logic [15:0] disp_ram [0:4095];
    logic [7:0]  font_rom [0:4095];

    int tests = 0;
    int fails = 0;
    int base_m = 0;
    int scan_m = 0;

    text_scanout #(
        .TEXT_COLS (COLS),
        .TEXT_ROWS (ROWS),
        .FONT_H    (FH),
        .ADDR_W    (AW)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_start_i (frame_start_i),
        .line_start_i  (line_start_i),
        .rd_en_o       (rd_en_o),
        .rd_addr_o     (rd_addr_o),
        .rd_data_i     (rd_data_i),
        .font_addr_o   (font_addr_o),
        .font_data_i   (font_data_i),
        .pix_valid_o   (pix_valid_o),
        .pix_color_o   (pix_color_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories, one cycle latency.
    always @(posedge clk) begin
        if (rd_en_o)
            rd_data_i <= disp_ram[rd_addr_o];
        font_data_i <= font_rom[font_addr_o];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Colour of pixel x of a line at the given row base and scanline.
    function automatic logic [3:0] model_pix(int base, int scan, int x);
        logic [15:0] w;
        logic [7:0]  g;
        logic [3:0]  s;
        s = 4'(scan);
        w = disp_ram[base + x / 8];
        g = font_rom[{w[7:0], s}];
        return g[7 - (x % 8)] ? w[11:8] : w[15:12];
    endfunction

    task automatic model_advance();
        scan_m++;
        if (scan_m == FH) begin
            scan_m = 0;
            base_m += COLS;
            if (base_m >= COLS * ROWS)
                base_m = 0;
        end
    endtask

    // Cycle c counts from the cycle in which line_start_i was sampled.
    task automatic check_cycle(input int c);
        bit          fetch;
        bit          valid;
        logic [15:0] w;
        logic [3:0]  s;
        logic [3:0]  col;
        fetch = (c % 8 == 0) && (c < LINE_PIX);
        chk("rd_en", 32'(rd_en_o), 32'(fetch));
        if (fetch)
            chk("rd_addr", 32'(rd_addr_o), 32'(base_m + c / 8));
        if ((c % 8 == 1) && (c < LINE_PIX)) begin
            w = disp_ram[base_m + c / 8];
            s = 4'(scan_m);
            chk("font_addr", 32'(font_addr_o), 32'({w[7:0], s}));
        end
        valid = (c >= 3) && (c <= LINE_PIX + 2);
        col   = valid ? model_pix(base_m, scan_m, c - 3) : 4'd0;
        chk("pix_valid", 32'(pix_valid_o), 32'(valid));
        chk("pix_color", 32'(pix_color_o), 32'(col));
    endtask

    // Follow one line from cycle 0; abort_c >= 0 restarts the line at that cycle.
    task automatic scan_line(input int abort_c);
        for (int c = 0; c <= LINE_PIX + 3; c++) begin
            check_cycle(c);
            if (c == abort_c) begin
                line_start_i = 1'b1;
                @(negedge clk);
                line_start_i = 1'b0;
                abort_c = -1;
                c = -1;
                continue;
            end
            if (c < LINE_PIX + 3)
                @(negedge clk);
        end
        model_advance();
    endtask

    task automatic new_line(input bit with_frame, input int abort_c);
        line_start_i  = 1'b1;
        frame_start_i = with_frame;
        @(negedge clk);
        line_start_i  = 1'b0;
        frame_start_i = 1'b0;
        if (with_frame) begin
            base_m = 0;
            scan_m = 0;
        end
        scan_line(abort_c);
    endtask

    initial begin
        reset_n       = 1'b0;
        frame_start_i = 1'b0;
        line_start_i  = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            disp_ram[i] = 16'($urandom);
            font_rom[i] = 8'($urandom);
        end
        disp_ram[0]      = 16'h1241;
        font_rom[12'h410] = 8'b1000_0001;

        // Reset held with line starts pulsing: nothing may be fetched or shown.
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            line_start_i = (i % 2 == 0);
            @(negedge clk);
            chk("rst_rd_en", 32'(rd_en_o), 32'd0);
            chk("rst_rd_addr", 32'(rd_addr_o), 32'd0);
            chk("rst_font_addr", 32'(font_addr_o), 32'd0);
            chk("rst_pix_valid", 32'(pix_valid_o), 32'd0);
            chk("rst_pix_color", 32'(pix_color_o), 32'd0);
        end
        reset_n      = 1'b1;
        line_start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_rd_en", 32'(rd_en_o), 32'd0);
            chk("post_rst_pix_valid", 32'(pix_valid_o), 32'd0);
        end

        // Frame start alone does not begin a line.
        frame_start_i = 1'b1;
        @(negedge clk);
        frame_start_i = 1'b0;
        base_m = 0;
        scan_m = 0;
        chk("frame_no_fetch", 32'(rd_en_o), 32'd0);
        @(negedge clk);
        chk("frame_no_fetch2", 32'(rd_en_o), 32'd0);

        // First row: 16 scanlines (first cell is the directed 16'h1241 pattern).
        for (int i = 0; i < FH; i++)
            new_line(1'b0, -1);
        // Second row, scanlines 0..2 with two aborts (mid-pixel and in drain).
        new_line(1'b0, -1);
        new_line(1'b0, 103);
        new_line(1'b0, LINE_PIX + 1);
        // Rest of the second row, then the frame wraps back to address 0.
        for (int i = 0; i < FH - 3; i++)
            new_line(1'b0, -1);
        new_line(1'b0, -1);
        new_line(1'b0, -1);
        // Frame start coinciding with a line start mid-frame.
        new_line(1'b1, -1);

        // Reset in the middle of a line kills it and clears row/scanline.
        line_start_i = 1'b1;
        @(negedge clk);
        line_start_i = 1'b0;
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        base_m = 0;
        scan_m = 0;
        for (int i = 0; i < 5; i++) begin
            chk("midrst_rd_en", 32'(rd_en_o), 32'd0);
            chk("midrst_pix_valid", 32'(pix_valid_o), 32'd0);
            @(negedge clk);
        end
        new_line(1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
